cond_unit: RTL

- Parametrised conditional-execution unit for the ARMv4 processor's decode/execute boundary.
- Holds NUM_BANKS architectural NZCV flag registers and evaluates the 4-bit condition field against the selected bank.
- Gates PCSrc/RegWrite/MemWrite and updates flags under per-field write enables.
- Adds a predicated-block mode: one start instruction places the next N instructions under a latched condition.

---
 rtl/cond_pkg.sv | 52 +++++
 rtl/cond_eval_comb.sv | 14 +
 rtl/cond_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared types and the condition-code evaluator for the ARMv4 conditional-execution unit.
package cond_pkg;

   // The 4-bit instruction condition field. NV (4'b1111) is undefined on ARMv4.
   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
   } cond_t;

   // Architectural flags. The bit order matches the ALUFlags bus {N,Z,C,V}.
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   // Predicated-block state.
   typedef enum logic {
      BLK_IDLE   = 1'b0,
      BLK_ACTIVE = 1'b1
   } blk_state_t;

   // Condition passes for the given flags. NV never passes, so the result is never X.
   function automatic logic cond_eval(input cond_t cond, input flags_t f);
      logic ge;
      logic pass;
      ge = (f.n == f.v);
      case (cond)
         EQ:      pass = f.z;
         NE:      pass = ~f.z;
         CS:      pass = f.c;
         CC:      pass = ~f.c;
         MI:      pass = f.n;
         PL:      pass = ~f.n;
         VS:      pass = f.v;
         VC:      pass = ~f.v;
         HI:      pass = f.c & ~f.z;
         LS:      pass = ~(f.c & ~f.z);
         GE:      pass = ge;
         LT:      pass = ~ge;
         GT:      pass = ~f.z & ge;
         LE:      pass = ~(~f.z & ge);
         AL:      pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/cond_eval_comb.sv
// Pure combinational condition evaluator. The branch predictor uses it as well.
module cond_eval_comb
   import cond_pkg::*;
(
   input  cond_t  cond_i,
   input  flags_t flags_i,
   output logic   cond_ex_o,
   output logic   undef_o
);

   assign cond_ex_o = cond_eval(cond_i, flags_i);
   assign undef_o   = (cond_i == NV);

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: banked NZCV flags, control gating and predicated blocks.
module cond_unit
   import cond_pkg::*;
#(
   parameter  int NUM_BANKS = 2,
   parameter  int MAX_BLOCK = 4,
   localparam int BW        = $clog2(MAX_BLOCK + 1),
   localparam int BSW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic           flush,
   input  logic [3:0]     Cond,
   input  logic [3:0]     ALUFlags,
   input  logic [1:0]     FlagW,
   input  logic [BSW-1:0] BankSel,
   input  logic           PCS,
   input  logic           RegW,
   input  logic           MemW,
   input  logic           NoWrite,
   input  logic           BlockStart,
   input  logic [BW-1:0]  BlockLen,
   output logic           PCSrc,
   output logic           RegWrite,
   output logic           MemWrite,
   output logic           CondEx,
   output logic           Undef,
   output logic [3:0]     Flags,
   output logic           BlockActive,
   output logic [BW-1:0]  BlockRemain
);

   flags_t        banks_q [NUM_BANKS];
   blk_state_t    state_q;
   cond_t         blk_cond_q;
   logic [BW-1:0] remain_q;

   flags_t        sel_flags;
   flags_t        flags_d;
   cond_t         eff_cond;
   logic          bank_ok;
   logic          cond_ex;
   logic          undef;
   logic          exec;
   logic [BW-1:0] blk_len_clamped;

   assign bank_ok     = (int'(BankSel) < NUM_BANKS);
   assign BlockActive = (state_q == BLK_ACTIVE);
   assign BlockRemain = remain_q;

   // Read the selected bank and choose which condition governs this instruction.
   // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sel_flags = '0;
      if (bank_ok) begin
         sel_flags = banks_q[BankSel];
      end
      eff_cond = BlockActive ? blk_cond_q : cond_t'(Cond);
   end

   cond_eval_comb u_eval (
      .cond_i    (eff_cond),
      .flags_i   (sel_flags),
      .cond_ex_o (cond_ex),
      .undef_o   (undef)
   );

   // The block opener is consumed by the block logic and never executes itself.
   assign exec     = ~reset & en & ~flush & cond_ex & ~(BlockStart & ~BlockActive);
   assign CondEx   = cond_ex;
   assign Undef    = undef;
   assign Flags    = sel_flags;
   assign PCSrc    = PCS & exec;
   assign RegWrite = RegW & ~NoWrite & exec;
   assign MemWrite = MemW & exec;

   assign blk_len_clamped = (BlockLen > BW'(MAX_BLOCK)) ? BW'(MAX_BLOCK) : BlockLen;

   // Merge ALU flags into the selected bank under the per-field write enables.
   always_comb begin
      flags_d = sel_flags;
      if (FlagW[1]) begin
         flags_d.n = ALUFlags[3];
         flags_d.z = ALUFlags[2];
      end
      if (FlagW[0]) begin
         flags_d.c = ALUFlags[1];
         flags_d.v = ALUFlags[0];
      end
   end

   // Flag banks: only the selected bank changes, and only when the instruction executes.
   // NOTE: the banks are architectural state that software reads before writing, so every entry is reset rather than left to power-up values.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            banks_q[i] <= '0;
         end
      end else if (exec && bank_ok) begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         banks_q[BankSel] <= flags_d;
      end
   end

   // Predicated-block FSM: open on a valid start, count down per instruction, cancel on flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= BLK_IDLE;
         remain_q   <= '0;
         blk_cond_q <= AL;
      end else if (en) begin
         if (flush) begin
            state_q  <= BLK_IDLE;
            remain_q <= '0;
         end else begin
            case (state_q)
               BLK_IDLE: begin
                  if (BlockStart && (BlockLen != '0)) begin
                     state_q    <= BLK_ACTIVE;
                     blk_cond_q <= cond_t'(Cond);
                     remain_q   <= blk_len_clamped;
                  end
               end
               BLK_ACTIVE: begin
                  remain_q <= remain_q - BW'(1);
                  if (remain_q == BW'(1)) begin
                     state_q <= BLK_IDLE;
                  end
               end
               default: begin
                  state_q  <= BLK_IDLE;
                  remain_q <= '0;
               end
            endcase
         end
      end
   end

endmodule
